// File: rtl/ps2_scan_decoder_if.sv
// ps2_scan_decoder_if
//   Groups the byte input, key-event handshake and status signals of the
//   PS/2 scan-code decoder.
//   slave  : the decoder side (consumes bytes, produces events/status)
//   master : the driving side (receiver + keyboard application logic)
//   byte_in/byte_tick   : received data byte and its one-cycle strobe
//   ev_code/ev_ext/ev_brk/ev_valid/ev_ready : FWFT event handshake
//   overrun/ovr_clr     : sticky event-drop flag and its clear
//   proto_err           : one-cycle protocol error / timeout pulse
interface ps2_scan_decoder_if;
    logic [7:0] byte_in;
    logic       byte_tick;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic       ev_valid;
    logic       ev_ready;
    logic       overrun;
    logic       ovr_clr;
    logic       proto_err;

    modport slave (
        input  byte_in, byte_tick, ev_ready, ovr_clr,
        output ev_code, ev_ext, ev_brk, ev_valid, overrun, proto_err
    );

    modport master (
        output byte_in, byte_tick, ev_ready, ovr_clr,
        input  ev_code, ev_ext, ev_brk, ev_valid, overrun, proto_err
    );
endinterface

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder
//   Parses Set-2 scan-code byte sequences (plain, E0 extended, F0 break,
//   E0 F0 extended-break) into key events, buffered in a FWFT FIFO.
//   A watchdog returns the parser to IDLE if a prefix is left hanging.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : ps2_scan_decoder_if.slave (bytes in, events/status out)
module ps2_scan_decoder #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 250000
) (
    input  logic                      clk,
    input  logic                      reset,
    ps2_scan_decoder_if.slave         bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] tcnt;
    logic          timeout;
    logic          bad_byte, is_e0, is_f0, is_ignored;
    logic          push, err;
    logic [9:0]    push_ev;

    // FIFO storage: {ext, brk, code}
    logic [DEPTH-1:0][9:0] mem;
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  empty, full, pop;
    logic [9:0]            head;

    assign is_e0      = bus.byte_in == 8'hE0;
    assign is_f0      = bus.byte_in == 8'hF0;
    assign bad_byte   = bus.byte_in == 8'h00 || bus.byte_in == 8'hFF;
    // Keyboard status/ack bytes that carry no key information
    assign is_ignored = bus.byte_in inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1};

    // A byte on the same cycle always wins over the watchdog
    assign timeout = (state != IDLE) && !bus.byte_tick && (tcnt == TMO_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        if (bus.byte_tick) begin
            case (state)
                IDLE:    if (!bad_byte && is_e0)      state_nx = EXT;
                         else if (!bad_byte && is_f0) state_nx = BRK;
                EXT:     if (is_f0)      state_nx = EXT_BRK;
                         else if (!is_e0) state_nx = IDLE;
                BRK:     if (!is_f0)     state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end else if (timeout) begin
            state_nx = IDLE;
        end
    end

    // ---------------- FSM: outputs (push / error) ----------------
    always_comb begin
        push    = 1'b0;
        push_ev = '0;
        err     = 1'b0;
        if (bus.byte_tick) begin
            if (bad_byte) begin
                err = 1'b1;
            end else begin
                case (state)
                    IDLE: if (!is_e0 && !is_f0 && !is_ignored) begin
                        push = 1'b1; push_ev = {2'b00, bus.byte_in};
                    end
                    EXT: if (!is_e0 && !is_f0) begin
                        push = 1'b1; push_ev = {2'b10, bus.byte_in};
                    end
                    BRK: if (is_e0) err = 1'b1;
                         else if (!is_f0) begin
                        push = 1'b1; push_ev = {2'b01, bus.byte_in};
                    end
                    default: if (is_e0 || is_f0) err = 1'b1;
                         else begin
                        push = 1'b1; push_ev = {2'b11, bus.byte_in};
                    end
                endcase
            end
        end else if (timeout) begin
            err = 1'b1;
        end
    end

    // ---------------- prefix watchdog ----------------
    always_ff @(posedge clk) begin
        if (reset || bus.byte_tick || state == IDLE || timeout) tcnt <= '0;
        else                                                    tcnt <= tcnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) bus.proto_err <= 1'b0;
        else       bus.proto_err <= err;
    end

    // ---------------- event FIFO (FWFT) ----------------
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign pop   = !empty && bus.ev_ready;

    // A pop on the same cycle frees the slot, so a full FIFO still accepts
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && (!full || pop)) begin
                mem[wr_ptr[AW-1:0]] <= push_ev;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                     bus.overrun <= 1'b0;
        else if (push && full && !pop) bus.overrun <= 1'b1;
        else if (bus.ovr_clr)          bus.overrun <= 1'b0;
    end

    assign head         = empty ? 10'd0 : mem[rd_ptr[AW-1:0]];
    assign bus.ev_valid = !empty;
    assign bus.ev_ext   = head[9];
    assign bus.ev_brk   = head[8];
    assign bus.ev_code  = head[7:0];
endmodule
